// File: rtl/pattern_sweep_if.sv
// Bus between pattern_sweep and the board/bench side: sweep control, expected
// signature, DUT stimulus/response and the sweep status outputs.
interface pattern_sweep_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 3
);
    logic              start;
    logic              abort;
    logic [15:0]       sig_exp;
    logic [N_OUT-1:0]  dut_out;
    logic [N_IN-1:0]   pat;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       sig;

    modport master (
        output start, abort, sig_exp, dut_out,
        input  pat, busy, done, pass, sig
    );

    modport slave (
        input  start, abort, sig_exp, dut_out,
        output pat, busy, done, pass, sig
    );
endinterface

// File: rtl/pattern_sweep.sv
// Exhaustive input sweep with 16-bit MISR signature and pass/fail compare.
// Optional macro SWEEP_GRAY_EN switches the pattern order from binary to reflected Gray.
module pattern_sweep #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 3,
    parameter int HOLD  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    pattern_sweep_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

    localparam int              HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N_IN-1:0] CNT_LAST  = '1;

    state_t          state, state_nx;
    logic [N_IN-1:0] cnt, cnt_nx;
    logic [N_IN-1:0] pat_q, pat_nx;
    logic [HW-1:0]   hold_cnt, hold_nx;
    logic            busy_q, busy_nx;
    logic            done_q, done_nx;
    logic            pass_q, pass_nx;
    logic [15:0]     sig_q, sig_nx, misr_nx;

    function automatic logic [N_IN-1:0] to_pat(input logic [N_IN-1:0] c);
`ifdef SWEEP_GRAY_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    always_comb begin
        misr_nx = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ 16'(bus.dut_out);
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pat_nx   = pat_q;
        hold_nx  = hold_cnt;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        pass_nx  = pass_q;
        sig_nx   = sig_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = DRIVE;
                    cnt_nx   = '0;
                    pat_nx   = '0;
                    hold_nx  = '0;
                    busy_nx  = 1'b1;
                    sig_nx   = '0;
                end
            end
            DRIVE: begin
                // abort takes priority over a sample falling on the same edge
                if (bus.abort) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else if (hold_cnt == HOLD_LAST) begin
                    hold_nx = '0;
                    sig_nx  = misr_nx;
                    if (cnt == CNT_LAST) begin
                        state_nx = FINISH;
                        busy_nx  = 1'b0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                        pat_nx = to_pat(cnt + 1'b1);
                    end
                end else begin
                    hold_nx = hold_cnt + HW'(1);
                end
            end
            FINISH: begin
                state_nx = IDLE;
                done_nx  = 1'b1;
                pass_nx  = (sig_q == bus.sig_exp);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pat_q    <= '0;
            hold_cnt <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            sig_q    <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            pat_q    <= pat_nx;
            hold_cnt <= hold_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
            pass_q   <= pass_nx;
            sig_q    <= sig_nx;
        end
    end

    assign bus.pat  = pat_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.pass = pass_q;
    assign bus.sig  = sig_q;

endmodule
